// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the instruction/data memory arbiter
// Contents:
//   mem_req_t   : request payload (addr, wdata, we)
//   mem_resp_t  : response payload (rdata)
//   arb_state_e : grant FSM states
//   src_e       : requester encoding (SRC_IFETCH=0, SRC_DATA=1)
//   tag_t       : per-transaction tag kept in the in-order tag FIFO
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
    } mem_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IFETCH = 2'd1,
        ARB_DATA   = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IFETCH = 1'b0,
        SRC_DATA   = 1'b1
    } src_e;

    typedef struct packed {
        src_e src;
        logic killed;
    } tag_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// rtl/mem_arb_tag_fifo.sv - in-order tag FIFO tracking outstanding memory transactions
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push         : write a tag {push_src, killed} at the tail
//   push_src     : source of the transaction being pushed
//   push_killed  : transaction was already killed before it was accepted
//   pop          : retire the head tag
//   kill_all     : mark every ifetch tag (including one pushed this cycle) killed
//   head         : tag at the head (valid when !empty)
//   full, empty  : occupancy flags
module mem_arb_tag_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  src_e push_src,
    input  logic push_killed,
    input  logic pop,
    input  logic kill_all,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    tag_t             entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '{src: SRC_IFETCH, killed: 1'b0};
            end
        end else begin
            if (kill_all) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].src == SRC_IFETCH) begin
                        entries[i].killed <= 1'b1;
                    end
                end
            end
            // Later assignment wins, so a same-cycle push still sees kill_all.
            if (push) begin
                entries[wr_ptr] <= '{src: push_src,
                                     killed: (push_src == SRC_IFETCH) && (push_killed || kill_all)};
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data requests onto one in-order memory port
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data
// always beats ifetch.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   flush                        : kill all in-flight instruction fetches
//   ifetch_req_{valid,ready,data}: fetch-stage request
//   ifetch_resp_{valid,ready,data}: fetch-stage response
//   data_req_{valid,ready,data}  : execute mem-unit request
//   data_resp_{valid,ready,data} : execute mem-unit response
//   mem_req_{valid,ready,data}   : shared memory port request
//   mem_resp_{valid,ready,data}  : shared memory port response (in request order)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      ifetch_req_valid,
    output logic      ifetch_req_ready,
    input  mem_req_t  ifetch_req_data,
    output logic      ifetch_resp_valid,
    input  logic      ifetch_resp_ready,
    output mem_resp_t ifetch_resp_data,
    input  logic      data_req_valid,
    output logic      data_req_ready,
    input  mem_req_t  data_req_data,
    output logic      data_resp_valid,
    input  logic      data_resp_ready,
    output mem_resp_t data_resp_data,
    output logic      mem_req_valid,
    input  logic      mem_req_ready,
    output mem_req_t  mem_req_data,
    input  logic      mem_resp_valid,
    output logic      mem_resp_ready,
    input  mem_resp_t mem_resp_data
);

    arb_state_e state;
    arb_state_e state_next;
    src_e       pick_src;
    src_e       gnt_src;
    mem_req_t   hold_data;
    logic       hold_killed;
    logic       req_valid_int;
    logic       req_hs;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    tag_t       head;
    logic       ifetch_resp_valid_int;
    logic       data_resp_valid_int;
    logic       mem_resp_ready_int;

    // ------------------------------------------------------------------
    // Source selection in ARB_IDLE
    // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    src_e last_grant;

    always_comb begin
        pick_src = SRC_IFETCH;
        if (ifetch_req_valid && data_req_valid) begin
            pick_src = (last_grant == SRC_IFETCH) ? SRC_DATA : SRC_IFETCH;
        end else if (data_req_valid) begin
            pick_src = SRC_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_IFETCH;
        end else if (req_hs) begin
            last_grant <= gnt_src;
        end
    end
`else
    always_comb begin
        pick_src = data_req_valid ? SRC_DATA : SRC_IFETCH;
    end
`endif

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_valid_int = 1'b0;
        gnt_src       = pick_src;
        mem_req_data  = '0;
        case (state)
            ARB_IDLE: begin
                if (!fifo_full && (ifetch_req_valid || data_req_valid)) begin
                    req_valid_int = 1'b1;
                    mem_req_data  = (pick_src == SRC_DATA) ? data_req_data : ifetch_req_data;
                    if (!mem_req_ready) begin
                        state_next = (pick_src == SRC_DATA) ? ARB_DATA : ARB_IFETCH;
                    end
                end
            end
            ARB_IFETCH: begin
                gnt_src       = SRC_IFETCH;
                req_valid_int = 1'b1;
                mem_req_data  = hold_data;
                if (mem_req_ready) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                gnt_src       = SRC_DATA;
                req_valid_int = 1'b1;
                mem_req_data  = hold_data;
                if (mem_req_ready) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // The held request is replayed from a local copy so a fetch stage that drops
    // its request on flush cannot disturb the transaction already offered.
    // hold_killed remembers a flush that hit the fetch before it was accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data   <= '0;
            hold_killed <= 1'b0;
        end else begin
            if (state == ARB_IDLE && req_valid_int && !mem_req_ready) begin
                hold_data <= mem_req_data;
            end
            if (req_hs) begin
                hold_killed <= 1'b0;
            end else if (flush && req_valid_int && gnt_src == SRC_IFETCH) begin
                hold_killed <= 1'b1;
            end
        end
    end

    assign mem_req_valid    = rst & req_valid_int;
    assign req_hs           = mem_req_valid & mem_req_ready;
    assign ifetch_req_ready = req_hs & (gnt_src == SRC_IFETCH);
    assign data_req_ready   = req_hs & (gnt_src == SRC_DATA);

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    mem_arb_tag_fifo #(
        .DEPTH(DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (req_hs),
        .push_src    (gnt_src),
        .push_killed (hold_killed & (gnt_src == SRC_IFETCH)),
        .pop         (fifo_pop),
        .kill_all    (flush),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Response routing by head tag
    // ------------------------------------------------------------------
    always_comb begin
        ifetch_resp_valid_int = 1'b0;
        data_resp_valid_int   = 1'b0;
        mem_resp_ready_int    = 1'b0;
        if (fifo_empty) begin
            // Stray response: swallow it so the memory side cannot lock up.
            mem_resp_ready_int = 1'b1;
        end else if (head.src == SRC_DATA) begin
            data_resp_valid_int = mem_resp_valid;
            mem_resp_ready_int  = data_resp_ready;
        end else if (head.killed || flush) begin
            mem_resp_ready_int = 1'b1;
        end else begin
            ifetch_resp_valid_int = mem_resp_valid;
            mem_resp_ready_int    = ifetch_resp_ready;
        end
    end

    assign ifetch_resp_valid = rst & ifetch_resp_valid_int;
    assign data_resp_valid   = rst & data_resp_valid_int;
    assign mem_resp_ready    = rst & mem_resp_ready_int;
    assign ifetch_resp_data  = mem_resp_data;
    assign data_resp_data    = mem_resp_data;
    assign fifo_pop          = mem_resp_valid & mem_resp_ready & ~fifo_empty;

    a_no_resp_when_empty: assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp_valid && fifo_empty));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic      clk;
    logic      rst;
    logic      flush;
    logic      ifetch_req_valid;
    logic      ifetch_req_ready;
    mem_req_t  ifetch_req_data;
    logic      ifetch_resp_valid;
    logic      ifetch_resp_ready;
    mem_resp_t ifetch_resp_data;
    logic      data_req_valid;
    logic      data_req_ready;
    mem_req_t  data_req_data;
    logic      data_resp_valid;
    logic      data_resp_ready;
    mem_resp_t data_resp_data;
    logic      mem_req_valid;
    logic      mem_req_ready;
    mem_req_t  mem_req_data;
    logic      mem_resp_valid;
    logic      mem_resp_ready;
    mem_resp_t mem_resp_data;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .ifetch_req_valid (ifetch_req_valid),
        .ifetch_req_ready (ifetch_req_ready),
        .ifetch_req_data  (ifetch_req_data),
        .ifetch_resp_valid(ifetch_resp_valid),
        .ifetch_resp_ready(ifetch_resp_ready),
        .ifetch_resp_data (ifetch_resp_data),
        .data_req_valid   (data_req_valid),
        .data_req_ready   (data_req_ready),
        .data_req_data    (data_req_data),
        .data_resp_valid  (data_resp_valid),
        .data_resp_ready  (data_resp_ready),
        .data_resp_data   (data_resp_data),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_data     (mem_req_data),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_ready   (mem_resp_ready),
        .mem_resp_data    (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush             = 1'b0;
        ifetch_req_valid  = 1'b0;
        data_req_valid    = 1'b0;
        ifetch_resp_ready = 1'b1;
        data_resp_ready   = 1'b1;
        mem_req_ready     = 1'b0;
        mem_resp_valid    = 1'b0;
        ifetch_req_data   = '{addr: 32'h1000_0000, wdata: '0, we: 1'b0};
        data_req_data     = '{addr: 32'h2000_0000, wdata: 32'hDEAD_BEEF, we: 1'b1};
        mem_resp_data     = '{rdata: 32'h0};
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        ifetch_req_valid = 1'b1;
        data_req_valid   = 1'b1;
        mem_req_ready    = 1'b1;
        mem_resp_valid   = 1'b1;
        cyc();
        cyc();
        #2;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (ifetch_req_ready !== 1'b0 || data_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b%b exp=00", ifetch_req_ready, data_req_ready); end
        checks++; if (mem_resp_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_resp_ready got=%b exp=0", mem_resp_ready); end
        checks++; if (ifetch_resp_valid !== 1'b0 || data_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b%b exp=00", ifetch_resp_valid, data_resp_valid); end
        checks++; if (dut.state !== ARB_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ARB_IDLE); end
        checks++; if (dut.u_tag_fifo.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.u_tag_fifo.count); end
        clear_inputs();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    // Both sources valid with an always-ready memory for 4 cycles, then drain.
    task automatic test_priority();
        src_e exp_src [4];
        int   n_data;
`ifdef MEM_ARB_RR_EN
        exp_src[0] = SRC_DATA;
        exp_src[1] = SRC_IFETCH;
        exp_src[2] = SRC_DATA;
        exp_src[3] = SRC_IFETCH;
`else
        exp_src[0] = SRC_DATA;
        exp_src[1] = SRC_DATA;
        exp_src[2] = SRC_DATA;
        exp_src[3] = SRC_DATA;
`endif
        n_data = 0;
        clear_inputs();
        ifetch_req_valid = 1'b1;
        data_req_valid   = 1'b1;
        mem_req_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL prio_valid[%0d] got=%b exp=1", i, mem_req_valid); end
            checks++; if (data_req_ready !== (exp_src[i] == SRC_DATA)) begin failures++; $display("FAIL prio_data_ready[%0d] got=%b exp=%b", i, data_req_ready, exp_src[i] == SRC_DATA); end
            checks++; if (ifetch_req_ready !== (exp_src[i] == SRC_IFETCH)) begin failures++; $display("FAIL prio_ifetch_ready[%0d] got=%b exp=%b", i, ifetch_req_ready, exp_src[i] == SRC_IFETCH); end
            checks++; if (mem_req_data.addr !== ((exp_src[i] == SRC_DATA) ? 32'h2000_0000 : 32'h1000_0000)) begin failures++; $display("FAIL prio_addr[%0d] got=%h", i, mem_req_data.addr); end
            if (data_req_ready === 1'b1) n_data++;
            cyc();
        end
        clear_inputs();
`ifdef MEM_ARB_RR_EN
        checks++; if (n_data != 2) begin failures++; $display("FAIL prio_data_grants got=%0d exp=2", n_data); end
`else
        checks++; if (n_data != 4) begin failures++; $display("FAIL prio_data_grants got=%0d exp=4", n_data); end
`endif
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = '{rdata: 32'hA0 + 32'(i)};
            #2;
            checks++; if (data_resp_valid !== (exp_src[i] == SRC_DATA)) begin failures++; $display("FAIL prio_resp_data_valid[%0d] got=%b", i, data_resp_valid); end
            checks++; if (ifetch_resp_valid !== (exp_src[i] == SRC_IFETCH)) begin failures++; $display("FAIL prio_resp_ifetch_valid[%0d] got=%b", i, ifetch_resp_valid); end
            checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL prio_resp_ready[%0d] got=%b exp=1", i, mem_resp_ready); end
            cyc();
        end
        clear_inputs();
        #2;
        checks++; if (dut.u_tag_fifo.count !== 3'd0) begin failures++; $display("FAIL prio_drained got=%0d exp=0", dut.u_tag_fifo.count); end
        cyc();
    endtask

    // Ifetch stalled 3 cycles; a data request arriving meanwhile waits.
    task automatic test_hold();
        clear_inputs();
        ifetch_req_valid = 1'b1;
        ifetch_req_data  = '{addr: 32'h1000_0040, wdata: '0, we: 1'b0};
        #2;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_data.addr !== 32'h1000_0040) begin failures++; $display("FAIL hold_first got=%b/%h exp=1/10000040", mem_req_valid, mem_req_data.addr); end
        checks++; if (ifetch_req_ready !== 1'b0) begin failures++; $display("FAIL hold_first_ready got=%b exp=0", ifetch_req_ready); end
        cyc();
        data_req_valid = 1'b1;
        data_req_data  = '{addr: 32'h2000_0080, wdata: 32'h1234, we: 1'b1};
        for (int i = 1; i < 3; i++) begin
            #2;
            checks++; if (dut.state !== ARB_IFETCH) begin failures++; $display("FAIL hold_state[%0d] got=%0d exp=%0d", i, dut.state, ARB_IFETCH); end
            checks++; if (mem_req_valid !== 1'b1 || mem_req_data.addr !== 32'h1000_0040) begin failures++; $display("FAIL hold_stable[%0d] got=%b/%h", i, mem_req_valid, mem_req_data.addr); end
            checks++; if (data_req_ready !== 1'b0) begin failures++; $display("FAIL hold_data_wait[%0d] got=%b exp=0", i, data_req_ready); end
            cyc();
        end
        mem_req_ready = 1'b1;
        #2;
        checks++; if (ifetch_req_ready !== 1'b1 || data_req_ready !== 1'b0) begin failures++; $display("FAIL hold_handshake got=%b%b exp=10", ifetch_req_ready, data_req_ready); end
        cyc();
        ifetch_req_valid = 1'b0;
        #2;
        checks++; if (dut.state !== ARB_IDLE) begin failures++; $display("FAIL hold_back_idle got=%0d exp=%0d", dut.state, ARB_IDLE); end
        checks++; if (data_req_ready !== 1'b1 || mem_req_data.addr !== 32'h2000_0080) begin failures++; $display("FAIL hold_data_grant got=%b/%h", data_req_ready, mem_req_data.addr); end
        cyc();
        data_req_valid = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = '{rdata: 32'hC0DE_0001};
        #2;
        checks++; if (ifetch_resp_valid !== 1'b1 || ifetch_resp_data.rdata !== 32'hC0DE_0001) begin failures++; $display("FAIL hold_resp_ifetch got=%b/%h", ifetch_resp_valid, ifetch_resp_data.rdata); end
        cyc();
        mem_resp_data = '{rdata: 32'hC0DE_0002};
        #2;
        checks++; if (data_resp_valid !== 1'b1 || ifetch_resp_valid !== 1'b0) begin failures++; $display("FAIL hold_resp_data got=%b%b exp=10", data_resp_valid, ifetch_resp_valid); end
        cyc();
        clear_inputs();
    endtask

    // Fill the 4-entry tag FIFO; the 5th request waits until a response pops.
    task automatic test_full();
        clear_inputs();
        data_req_valid = 1'b1;
        mem_req_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (data_req_ready !== 1'b1) begin failures++; $display("FAIL full_issue[%0d] got=%b exp=1", i, data_req_ready); end
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if (mem_req_valid !== 1'b0 || data_req_ready !== 1'b0) begin failures++; $display("FAIL full_block[%0d] got=%b%b exp=00", i, mem_req_valid, data_req_ready); end
            cyc();
        end
        mem_resp_valid = 1'b1;
        #2;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%b exp=0", mem_req_valid); end
        checks++; if (data_resp_valid !== 1'b1) begin failures++; $display("FAIL full_resp got=%b exp=1", data_resp_valid); end
        cyc();
        mem_resp_valid = 1'b0;
        #2;
        checks++; if (mem_req_valid !== 1'b1 || data_req_ready !== 1'b1) begin failures++; $display("FAIL full_grant_after_pop got=%b%b exp=11", mem_req_valid, data_req_ready); end
        cyc();
        data_req_valid = 1'b0;
        mem_req_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            #2;
            checks++; if (data_resp_valid !== 1'b1) begin failures++; $display("FAIL full_drain[%0d] got=%b exp=1", i, data_resp_valid); end
            cyc();
        end
        clear_inputs();
        #2;
        checks++; if (dut.u_tag_fifo.count !== 3'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", dut.u_tag_fifo.count); end
        cyc();
    endtask

    // Outstanding I,D,I then flush: only the data response is delivered.
    task automatic test_flush();
        clear_inputs();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifetch_req_valid = (i != 1);
            data_req_valid   = (i == 1);
            #2;
            checks++; if (ifetch_req_ready !== (i != 1) || data_req_ready !== (i == 1)) begin failures++; $display("FAIL flush_issue[%0d] got=%b%b", i, ifetch_req_ready, data_req_ready); end
            cyc();
        end
        clear_inputs();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = '{rdata: 32'hB0 + 32'(i)};
            #2;
            checks++; if (ifetch_resp_valid !== 1'b0) begin failures++; $display("FAIL flush_ifetch_valid[%0d] got=%b exp=0", i, ifetch_resp_valid); end
            checks++; if (data_resp_valid !== (i == 1)) begin failures++; $display("FAIL flush_data_valid[%0d] got=%b exp=%b", i, data_resp_valid, i == 1); end
            checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL flush_resp_ready[%0d] got=%b exp=1", i, mem_resp_ready); end
            if (i == 1) begin
                checks++; if (data_resp_data.rdata !== 32'hB1) begin failures++; $display("FAIL flush_data_rdata got=%h exp=b1", data_resp_data.rdata); end
            end
            cyc();
        end
        clear_inputs();
        #2;
        checks++; if (dut.u_tag_fifo.count !== 3'd0) begin failures++; $display("FAIL flush_drained got=%0d exp=0", dut.u_tag_fifo.count); end
        cyc();
    endtask

    // Flush while an ifetch is held, and flush in the same cycle as a push.
    task automatic test_flush_held();
        clear_inputs();
        ifetch_req_valid = 1'b1;
        ifetch_req_data  = '{addr: 32'h1000_0100, wdata: '0, we: 1'b0};
        cyc();
        flush            = 1'b1;
        ifetch_req_valid = 1'b0;
        #2;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_data.addr !== 32'h1000_0100) begin failures++; $display("FAIL flush_held_keep got=%b/%h exp=1/10000100", mem_req_valid, mem_req_data.addr); end
        cyc();
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        #2;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL flush_held_hs got=%b exp=1", mem_req_valid); end
        cyc();
        ifetch_req_valid = 1'b1;
        flush            = 1'b1;
        #2;
        checks++; if (ifetch_req_ready !== 1'b1) begin failures++; $display("FAIL flush_push_hs got=%b exp=1", ifetch_req_ready); end
        cyc();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            #2;
            checks++; if (ifetch_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin failures++; $display("FAIL flush_held_drop[%0d] got=%b%b exp=01", i, ifetch_resp_valid, mem_resp_ready); end
            cyc();
        end
        clear_inputs();
        #2;
        checks++; if (dut.u_tag_fifo.count !== 3'd0) begin failures++; $display("FAIL flush_held_drained got=%0d exp=0", dut.u_tag_fifo.count); end
        cyc();
    endtask

    // Reset with two outstanding and an ifetch grant held.
    task automatic test_reset_midflight();
        clear_inputs();
        data_req_valid = 1'b1;
        mem_req_ready  = 1'b1;
        cyc();
        cyc();
        data_req_valid   = 1'b0;
        mem_req_ready    = 1'b0;
        ifetch_req_valid = 1'b1;
        cyc();
        #2;
        checks++; if (dut.state !== ARB_IFETCH || dut.u_tag_fifo.count !== 3'd2) begin failures++; $display("FAIL midrst_pre got=%0d/%0d exp=%0d/2", dut.state, dut.u_tag_fifo.count, ARB_IFETCH); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0 || ifetch_req_ready !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b%b exp=00", mem_req_valid, ifetch_req_ready); end
        checks++; if (dut.u_tag_fifo.count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", dut.u_tag_fifo.count); end
        checks++; if (dut.state !== ARB_IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", dut.state, ARB_IDLE); end
        cyc();
        clear_inputs();
        rst = 1'b1;
        cyc();
        data_req_valid = 1'b1;
        data_req_data  = '{addr: 32'h2000_0F00, wdata: '0, we: 1'b0};
        mem_req_ready  = 1'b1;
        #2;
        checks++; if (dut.state !== ARB_IDLE || mem_req_valid !== 1'b1 || data_req_ready !== 1'b1) begin failures++; $display("FAIL midrst_fresh got=%0d/%b%b exp=%0d/11", dut.state, mem_req_valid, data_req_ready, ARB_IDLE); end
        checks++; if (mem_req_data.addr !== 32'h2000_0F00) begin failures++; $display("FAIL midrst_fresh_addr got=%h exp=20000f00", mem_req_data.addr); end
        cyc();
        clear_inputs();
        mem_resp_valid = 1'b1;
        #2;
        checks++; if (data_resp_valid !== 1'b1) begin failures++; $display("FAIL midrst_resp got=%b exp=1", data_resp_valid); end
        cyc();
        clear_inputs();
        #2;
        checks++; if (dut.u_tag_fifo.count !== 3'd0) begin failures++; $display("FAIL midrst_drained got=%0d exp=0", dut.u_tag_fifo.count); end
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        #1;
        test_reset();
        test_priority();
        test_hold();
        test_full();
        test_flush();
        test_flush_held();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum number of outstanding memory transactions (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  pipeline flush; kills in-flight instruction fetches.
REQ-005 ifetch_req  decoupled.in  mem_req_t  fetch-stage request.
REQ-006 ifetch_resp  decoupled.out  mem_resp_t  fetch-stage response.
REQ-007 data_req  decoupled.in  mem_req_t  execute mem-unit request.
REQ-008 data_resp  decoupled.out  mem_resp_t  execute mem-unit response.
REQ-009 mem_req  decoupled.out  mem_req_t  shared memory port request.
REQ-010 mem_resp  decoupled.in  mem_resp_t  shared memory port response, returned in request order.

Function
REQ-011 Grant FSM SHALL have states ARB_IDLE, ARB_IFETCH and ARB_DATA.
REQ-012 In ARB_IDLE with tag FIFO not full, a valid requester SHALL be selected by the priority rule, with mem_req.valid asserted and mem_req.data driven from it combinationally in the same cycle.
REQ-013 If the selected request is not accepted (mem_req.ready low), the FSM SHALL move to ARB_IFETCH/ARB_DATA and hold that source until the handshake, keeping valid and data stable.
REQ-014 Only the granted source's ready SHALL be asserted, equal to mem_req.ready; the other source's ready SHALL be 0.
REQ-015 On each mem_req handshake, a tag {src, killed} SHALL be pushed into an in-order FIFO, and the FSM SHALL return to ARB_IDLE.
REQ-016 With the FIFO full (count == DEPTH), mem_req.valid SHALL be 0 in ARB_IDLE; no push-on-pop bypass.
REQ-017 mem_resp SHALL be routed by the FIFO head tag: a response to src=data or to a non-killed ifetch drives that resp.valid, with mem_resp.ready equal to that resp.ready.
REQ-018 A response whose head tag is a killed ifetch SHALL be dropped: mem_resp.ready=1, no resp.valid.
REQ-019 The FIFO SHALL pop on a mem_resp handshake; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 A mem_resp.valid while the FIFO is empty SHALL be consumed (mem_resp.ready=1), dropped, and flagged by an assertion.
REQ-021 flush SHALL set killed on every ifetch entry in the FIFO, including one pushed in the same cycle; data entries SHALL never be killed.
REQ-022 flush in ARB_IFETCH SHALL NOT withdraw mem_req.valid; the transaction completes and its tag is pushed killed.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits.

Reset
REQ-024 While rst is low, the FSM SHALL be in ARB_IDLE, the FIFO pointers and count 0, the round-robin pointer set to "ifetch last", and all tag bits cleared.
REQ-025 All valid and ready outputs SHALL be 0 during reset, and outstanding memory transactions SHALL be forgotten.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, ties SHALL go to the source not granted last, and the last-grant pointer SHALL update on each handshake.
REQ-027 Without MEM_ARB_RR_EN, data_req SHALL always win over ifetch_req, and no last-grant register SHALL exist.

Structure
REQ-028 mem_req_t, mem_resp_t, arb_state_e and the src encoding (SRC_IFETCH=0, SRC_DATA=1) SHALL live in the shared types package.
REQ-029 The tag FIFO SHALL be a sub-module mem_arb_tag_fifo, parameterised by DEPTH, with a kill_all input.

Verification
REQ-030 Both sources valid, mem_req.ready=1, 4 cycles, no RR: 4 data grants, 0 ifetch grants; with RR: alternating D,I,D,I.
REQ-031 ifetch valid, mem_req.ready low 3 cycles: state ARB_IFETCH, data held stable; a data_req arriving meanwhile SHALL wait; handshake in cycle 4, then ARB_IDLE.
REQ-032 Issue 4 requests without responses (DEPTH=4): 5th request gets mem_req.valid=0 until the first response pops, then it is granted the following cycle.
REQ-033 Outstanding I,D,I, flush pulse, then 3 responses: ifetch_resp.valid never asserted; data_resp receives exactly the 2nd response.
REQ-034 Assert rst low with 2 outstanding and a grant held: all valids drop immediately, count=0; after release, a fresh request is granted in ARB_IDLE.
